sobel_window_gen: RTL

Raster-to-window front end for the Sobel datapath. Accepts one 8-bit grayscale pixel per cycle in raster order, buffers the two previous image lines, and emits every fully-interior 3x3 neighbourhood as a packed 72-bit window. The window format is exactly the one the Sobel stage consumes on its 72-bit window input. It sits between the image memory reader and the Sobel stage.

---
 rtl/sobel_window_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster pixel stream to 3x3 interior windows for the Sobel stage.
// Optional SOBEL_WIN_CNT_EN adds a saturating per-frame window counter output win_cnt.
module sobel_window_gen #(
    parameter int IMG_W = 100,
    parameter int IMG_H = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [71:0] win_out,
    output logic        win_valid,
    output logic        frame_done
`ifdef SOBEL_WIN_CNT_EN
    ,
    output logic [15:0] win_cnt
`endif
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_MIN = XW'(2);
    localparam logic [YW-1:0] Y_MIN = YW'(2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [7:0]      lb0 [IMG_W];
    logic [7:0]      lb1 [IMG_W];
    logic [15:0]     sr0, sr1, sr2;
    logic [7:0]      lb0_x, lb1_x;
    logic            accept, x_last, emit, go;

    assign lb0_x  = lb0[x];
    assign lb1_x  = lb1[x];
    assign accept = pix_valid & pix_ready;
    assign x_last = x == X_LAST;
    assign emit   = accept && x >= X_MIN && y >= Y_MIN;
    assign go     = state == IDLE && start;

    always_comb begin
        state_nx   = state;
        pix_ready  = state == RUN;
        frame_done = state == DONE;
        state_nx   = state == IDLE ? (start ? RUN : IDLE) :
                     state == RUN  ? (accept && x_last && y == Y_LAST ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (go) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            x <= x_last ? '0 : x + XW'(1);
            y <= x_last ? y + YW'(1) : y;
        end
    end

    // Each row register keeps the two older columns; the incoming column completes the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr0       <= '0;
            sr1       <= '0;
            sr2       <= '0;
            win_out   <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= emit;
            if (accept) begin
                sr0 <= {sr0[7:0], lb0_x};
                sr1 <= {sr1[7:0], lb1_x};
                sr2 <= {sr2[7:0], pix_in};
            end
            if (emit) win_out <= {sr0, lb0_x, sr1, lb1_x, sr2, pix_in};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[x] <= lb1_x;
            lb1[x] <= pix_in;
        end
    end

`ifdef SOBEL_WIN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           win_cnt <= '0;
        else if (go)                        win_cnt <= '0;
        else if (emit && win_cnt != 16'hFFFF) win_cnt <= win_cnt + 16'd1;
    end
`endif
endmodule
